// File: rtl/pu_riscv_pc_redirect_arb_if.sv
// IF-side redirect handshake: the arbiter offers a PC, IF holds it off with if_stall.
interface pu_riscv_pc_redirect_arb_if #(
   parameter int XLEN = 64
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            redirect_cacheflush;
   logic [1:0]      redirect_src;
   logic            if_stall;

   modport master (
      output redirect_valid, redirect_pc, redirect_cacheflush, redirect_src,
      input  if_stall
   );

   modport slave (
      input  redirect_valid, redirect_pc, redirect_cacheflush, redirect_src,
      output if_stall
   );
endinterface

// File: rtl/pu_riscv_pc_redirect_arb.sv
// Next-PC redirect arbiter: reset/ST/DU/BU sources -> one redirect to IF, then a pipe_flush window.
// Optional per-source accept counters under PU_RISCV_REDIRECT_STATS_EN.
module pu_riscv_pc_redirect_arb #(
   parameter int              XLEN         = 64,
   parameter logic [XLEN-1:0] PC_INIT      = 'h8000_0000,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic                             rstn,
   input  logic                             clk,
   input  logic                             st_flush,
   input  logic [XLEN-1:0]                  st_nxt_pc,
   input  logic                             du_we_pc,
   input  logic [XLEN-1:0]                  du_dato,
   input  logic                             du_stall,
   input  logic                             bu_flush,
   input  logic [XLEN-1:0]                  bu_nxt_pc,
   input  logic                             bu_cacheflush,
   pu_riscv_pc_redirect_arb_if.master       rif,
   output logic                             pipe_flush,
   output logic                             busy,
   output logic [31:0]                      stat_cnt_st,
   output logic [31:0]                      stat_cnt_du,
   output logic [31:0]                      stat_cnt_bu
);
   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [1:0] SRC_RST = 2'd0;
   localparam logic [1:0] SRC_ST  = 2'd1;
   localparam logic [1:0] SRC_DU  = 2'd2;
   localparam logic [1:0] SRC_BU  = 2'd3;

   typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

   state_t          state;
   logic            valid_q, cf_q;
   logic [XLEN-1:0] pc_q;
   logic [1:0]      src_q;
   logic [CW-1:0]   cnt;

   logic            bu_ok, req, xfer, take;
   logic [XLEN-1:0] req_pc;
   logic [1:0]      req_src, req_rank, cur_rank;
   logic            req_cf;

   assign xfer = valid_q & ~rif.if_stall;

   always_comb begin
      bu_ok    = bu_flush & ~du_stall & (state != FLUSH);
      req      = st_flush | du_we_pc | bu_ok;
      req_pc   = '0;
      req_src  = SRC_RST;
      req_rank = 2'd0;
      req_cf   = 1'b0;
      if (st_flush) begin
         req_pc   = st_nxt_pc & ~XLEN'(1);
         req_src  = SRC_ST;
         req_rank = 2'd3;
      end else if (du_we_pc) begin
         req_pc   = du_dato & ~XLEN'(1);
         req_src  = SRC_DU;
         req_rank = 2'd2;
      end else if (bu_ok) begin
         req_pc   = bu_nxt_pc & ~XLEN'(1);
         req_src  = SRC_BU;
         req_rank = 2'd1;
         req_cf   = bu_cacheflush;
      end
   end

   // A pending reset vector ranks lowest so any real request may overwrite it.
   always_comb begin
      case (src_q)
         SRC_ST:  cur_rank = 2'd3;
         SRC_DU:  cur_rank = 2'd2;
         SRC_BU:  cur_rank = 2'd1;
         default: cur_rank = 2'd0;
      endcase
   end

   // While holding, only equal/higher priority replaces; on the transfer edge any new request wins.
   always_comb begin
      take = 1'b0;
      if (req) begin
         case (state)
            IDLE, FLUSH: take = 1'b1;
            PEND:        take = xfer | (req_rank >= cur_rank);
            default:     take = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= PEND;
         valid_q    <= 1'b1;
         pc_q       <= PC_INIT & ~XLEN'(1);
         src_q      <= SRC_RST;
         cf_q       <= 1'b0;
         pipe_flush <= 1'b1;
         busy       <= 1'b1;
         cnt        <= '0;
      end else if (take) begin
         state      <= PEND;
         valid_q    <= 1'b1;
         pc_q       <= req_pc;
         src_q      <= req_src;
         cf_q       <= req_cf;
         pipe_flush <= 1'b1;
         busy       <= 1'b1;
      end else begin
         case (state)
            PEND: if (xfer) begin
               state   <= FLUSH;
               valid_q <= 1'b0;
               cnt     <= CW'(FLUSH_CYCLES - 1);
            end
            FLUSH: if (cnt == '0) begin
               state      <= IDLE;
               pipe_flush <= 1'b0;
               busy       <= 1'b0;
            end else begin
               cnt <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rif.redirect_valid      = valid_q;
   assign rif.redirect_pc         = pc_q;
   assign rif.redirect_src        = src_q;
   assign rif.redirect_cacheflush = cf_q;

`ifdef PU_RISCV_REDIRECT_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_cnt_st <= '0;
         stat_cnt_du <= '0;
         stat_cnt_bu <= '0;
      end else if (xfer) begin
         case (src_q)
            SRC_ST:  stat_cnt_st <= stat_cnt_st + 32'd1;
            SRC_DU:  stat_cnt_du <= stat_cnt_du + 32'd1;
            SRC_BU:  stat_cnt_bu <= stat_cnt_bu + 32'd1;
            default: ;
         endcase
      end
   end
`else
   assign stat_cnt_st = '0;
   assign stat_cnt_du = '0;
   assign stat_cnt_bu = '0;
`endif
endmodule
